// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM
// state encodings, ALU and mux select codes, and the control-word bundle.
package mips_ctrl_pkg;

  // Primary opcode field values recognised by the decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALU operation codes (zero-extended to the alu_op port width)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BEQ      = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  // Full datapath control word produced by the decoder
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ior_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch: extension opcodes fall into ILLEGAL when not enabled
  function automatic state_t decode_next(input logic [5:0] op, input logic ext);
    case (op)
      OP_RTYPE:        return S_R_EXEC;
      OP_LW, OP_SW:    return S_MEM_ADDR;
      OP_BEQ:          return S_BEQ;
      OP_J:            return ext ? S_JUMP : S_ILLEGAL;
      OP_ADDI, OP_ORI: return ext ? S_I_EXEC : S_ILLEGAL;
      default:         return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure state-to-control-word decoder. Only FETCH and MEM_WR look at
// mem_ready, so that PC/IR updates and the store's completion pulse happen
// only in the cycle the memory actually accepts the access.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_is_ori,
  output ctrl_t  o_ctrl
);

  // Decode the current state into the datapath control word
  always_comb begin
    // NOTE: default the whole word first so no path through the case leaves
    // a field unassigned, which would otherwise infer a latch.
    o_ctrl = '0;
    case (i_state)
      S_IDLE: ;
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_BROFF;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.ior_d      = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = i_is_ori ? ALU_OR : ALU_ADD;
      end
      S_I_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        o_ctrl.illegal_op = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Holds the state register and next-state
// logic; control outputs come from mc_ctrl_decode so they follow the state
// register directly and collapse to zero the instant reset asserts.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int ENABLE_EXT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic                mem_ready,
  output logic                regDst,
  output logic                aluSrcA,
  output logic                memToReg,
  output logic                regWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                iorD,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          pcSource,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_op
);

  localparam logic EXT = (ENABLE_EXT != 0);

  state_t r_state;
  logic   r_armed;   // set one edge after reset so IDLE lasts a full cycle
  logic   r_is_ori;  // captured at DECODE to pick the I-type ALU op
  ctrl_t  w_ctrl;

  // State register and next-state logic
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is assigned with <= so every flop samples pre-edge values;
    // the async reset branch drops to IDLE without waiting for a clock.
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_is_ori <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_armed <= 1'b1;
          if (r_armed) r_state <= S_FETCH;
        end
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_state  <= decode_next(op, EXT);
          r_is_ori <= (op == OP_ORI);
        end
        S_MEM_ADDR: r_state <= (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_BEQ, S_JUMP, S_I_WB, S_ILLEGAL:
                    r_state <= S_FETCH;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_is_ori    (r_is_ori),
    .o_ctrl      (w_ctrl)
  );

  assign regDst      = w_ctrl.reg_dst;
  assign aluSrcA     = w_ctrl.alu_src_a;
  assign memToReg    = w_ctrl.mem_to_reg;
  assign regWrite    = w_ctrl.reg_write;
  assign memRead     = w_ctrl.mem_read;
  assign memWrite    = w_ctrl.mem_write;
  assign iorD        = w_ctrl.ior_d;
  assign irWrite     = w_ctrl.ir_write;
  assign pcWrite     = w_ctrl.pc_write;
  assign pcWriteCond = w_ctrl.pc_write_cond;
  assign aluSrcB     = w_ctrl.alu_src_b;
  assign pcSource    = w_ctrl.pc_source;
  assign alu_op      = ALU_OP_W'(w_ctrl.alu_op);
  assign instr_done  = w_ctrl.instr_done;
  assign illegal_op  = w_ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of per-cycle {op, mem_ready,
// expected control word} records, plus hand-written sequences for the
// extension-disabled instance and for asynchronous reset during a store.
module tb_multicycle_control;

  // Expected-word bit masks, layout matches obs below
  localparam logic [18:0] M_REGDST = 19'h40000, M_SRCA = 19'h20000, M_M2R = 19'h10000;
  localparam logic [18:0] M_RW = 19'h08000, M_MR = 19'h04000, M_MW = 19'h02000;
  localparam logic [18:0] M_IORD = 19'h01000, M_IRW = 19'h00800, M_PCW = 19'h00400;
  localparam logic [18:0] M_PCWC = 19'h00200, B_FOUR = 19'h00080, B_IMM = 19'h00100;
  localparam logic [18:0] B_BROFF = 19'h00180, PS_ALUOUT = 19'h00020, PS_JUMP = 19'h00040;
  localparam logic [18:0] A_SUB = 19'h00004, A_FUNCT = 19'h00008, A_OR = 19'h0000C;
  localparam logic [18:0] M_DONE = 19'h00002, M_ILL = 19'h00001;

  localparam logic [18:0] E_IDLE  = 19'h0;
  localparam logic [18:0] E_FETCH = M_MR | M_IRW | M_PCW | B_FOUR;
  localparam logic [18:0] E_FWAIT = M_MR | B_FOUR;
  localparam logic [18:0] E_DEC   = B_BROFF;
  localparam logic [18:0] E_MADDR = M_SRCA | B_IMM;
  localparam logic [18:0] E_MRD   = M_MR | M_IORD;
  localparam logic [18:0] E_MWB   = M_RW | M_M2R | M_DONE;
  localparam logic [18:0] E_MWR   = M_MW | M_IORD;
  localparam logic [18:0] E_MWR_D = M_MW | M_IORD | M_DONE;
  localparam logic [18:0] E_REXEC = M_SRCA | A_FUNCT;
  localparam logic [18:0] E_RWB   = M_REGDST | M_RW | M_DONE;
  localparam logic [18:0] E_BEQ   = M_SRCA | A_SUB | M_PCWC | PS_ALUOUT | M_DONE;
  localparam logic [18:0] E_JUMP  = M_PCW | PS_JUMP | M_DONE;
  localparam logic [18:0] E_IADD  = M_SRCA | B_IMM;
  localparam logic [18:0] E_IOR   = M_SRCA | B_IMM | A_OR;
  localparam logic [18:0] E_IWB   = M_RW | M_DONE;
  localparam logic [18:0] E_ILL   = M_ILL | M_DONE;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_n2 = 1'b0;
  logic [5:0] op = '0, op2 = '0;
  logic mem_ready = 1'b1, mem_ready2 = 1'b1;

  logic regDst, aluSrcA, memToReg, regWrite, memRead, memWrite, iorD, irWrite;
  logic pcWrite, pcWriteCond, instr_done, illegal_op;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] alu_op;

  logic regDst2, aluSrcA2, memToReg2, regWrite2, memRead2, memWrite2, iorD2, irWrite2;
  logic pcWrite2, pcWriteCond2, instr_done2, illegal_op2;
  logic [1:0] aluSrcB2, pcSource2;
  logic [4:0] alu_op2;

  logic [18:0] obs, obs2;
  assign obs = {regDst, aluSrcA, memToReg, regWrite, memRead, memWrite, iorD, irWrite,
                pcWrite, pcWriteCond, aluSrcB, pcSource, alu_op, instr_done, illegal_op};
  assign obs2 = {regDst2, aluSrcA2, memToReg2, regWrite2, memRead2, memWrite2, iorD2, irWrite2,
                 pcWrite2, pcWriteCond2, aluSrcB2, pcSource2, alu_op2[2:0], instr_done2, illegal_op2};

  int n_checks = 0;
  int n_fail = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .regDst(regDst), .aluSrcA(aluSrcA), .memToReg(memToReg), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  multicycle_control #(.ALU_OP_W(5), .ENABLE_EXT(0)) dut_noext (
    .clk(clk), .rst_n(rst_n2), .op(op2), .mem_ready(mem_ready2),
    .regDst(regDst2), .aluSrcA(aluSrcA2), .memToReg(memToReg2), .regWrite(regWrite2),
    .memRead(memRead2), .memWrite(memWrite2), .iorD(iorD2), .irWrite(irWrite2),
    .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .aluSrcB(aluSrcB2), .pcSource(pcSource2),
    .alu_op(alu_op2), .instr_done(instr_done2), .illegal_op(illegal_op2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic r, input logic [18:0] e);
    vec_t v;
    v.op = o; v.rdy = r; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int ill_seen;
    int rw_seen;
    bit hit;

    // Per-cycle table, starting in the first cycle after reset release
    add(OP_R, 1, E_IDLE);   add(OP_R, 1, E_IDLE);
    // R-type
    add(OP_R, 1, E_FETCH);  add(OP_R, 1, E_DEC);   add(OP_R, 1, E_REXEC); add(OP_R, 1, E_RWB);
    // lw with one FETCH wait and two MEM_RD waits
    add(OP_LW, 0, E_FWAIT); add(OP_LW, 1, E_FETCH); add(OP_LW, 1, E_DEC); add(OP_LW, 1, E_MADDR);
    add(OP_LW, 0, E_MRD);   add(OP_LW, 0, E_MRD);   add(OP_LW, 1, E_MRD); add(OP_LW, 1, E_MWB);
    // sw with one MEM_WR wait
    add(OP_SW, 1, E_FETCH); add(OP_SW, 1, E_DEC);   add(OP_SW, 1, E_MADDR);
    add(OP_SW, 0, E_MWR);   add(OP_SW, 1, E_MWR_D);
    // beq, j
    add(OP_BEQ, 1, E_FETCH); add(OP_BEQ, 1, E_DEC); add(OP_BEQ, 1, E_BEQ);
    add(OP_J, 1, E_FETCH);   add(OP_J, 1, E_DEC);   add(OP_J, 1, E_JUMP);
    // addi, ori
    add(OP_ADDI, 1, E_FETCH); add(OP_ADDI, 1, E_DEC); add(OP_ADDI, 1, E_IADD); add(OP_ADDI, 1, E_IWB);
    add(OP_ORI, 1, E_FETCH);  add(OP_ORI, 1, E_DEC);  add(OP_ORI, 1, E_IOR);   add(OP_ORI, 1, E_IWB);
    // undecoded opcode, then park in FETCH
    add(OP_BAD, 1, E_FETCH); add(OP_BAD, 1, E_DEC); add(OP_BAD, 1, E_ILL);
    add(OP_BAD, 0, E_FWAIT);

    // Reset held across two edges: everything quiet on both instances
    step(); step();
    check("reset_outputs", 32'(obs), 32'(E_IDLE));
    check("reset_outputs_noext", 32'(obs2), 32'(E_IDLE));
    rst_n = 1'b1;

    foreach (vt[i]) begin
      op = vt[i].op;
      mem_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_op%b_rdy%0d", i, vt[i].op, vt[i].rdy), 32'(obs), 32'(vt[i].exp));
      @(posedge clk);
      #1;
    end

    // Store interrupted by async reset while waiting in MEM_WR
    op = OP_SW; mem_ready = 1'b1;
    #1 check("sw_fetch", 32'(obs), 32'(E_FETCH));
    step(); check("sw_decode", 32'(obs), 32'(E_DEC));
    step(); check("sw_maddr", 32'(obs), 32'(E_MADDR));
    mem_ready = 1'b0;
    step(); check("sw_mwr_wait", 32'(obs), 32'(E_MWR));
    #1 rst_n = 1'b0;
    #1 check("async_reset_memwrite", 32'(memWrite), 32'd0);
    check("async_reset_all", 32'(obs), 32'(E_IDLE));
    step(); check("reset_hold_idle", 32'(obs), 32'(E_IDLE));
    rst_n = 1'b1; mem_ready = 1'b1;
    step(); check("release_edge1_idle", 32'(obs), 32'(E_IDLE));
    step(); check("release_edge2_fetch", 32'(obs), 32'(E_FETCH));

    // ENABLE_EXT=0 instance: addi must take the illegal path exactly once
    op2 = OP_ADDI; mem_ready2 = 1'b1; rst_n2 = 1'b1;
    rw_seen = 0; hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      step();
      if (regWrite2) rw_seen++;
      if (illegal_op2) hit = 1'b1;
    end
    check("noext_illegal_reached", 32'(hit), 32'd1);
    check("noext_illegal_word", 32'(obs2), 32'(E_ILL));
    mem_ready2 = 1'b0;
    step();
    check("noext_after_illegal_fetch", 32'(obs2), 32'(E_FWAIT));
    ill_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (illegal_op2) ill_seen++;
      if (regWrite2) rw_seen++;
      if (alu_op2[4:3] != 2'b00) ill_seen += 100;
      step();
    end
    check("noext_single_pulse", 32'(ill_seen), 32'd0);
    check("noext_no_regwrite", 32'(rw_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of alu_op; SHALL be >= 3.
REQ-002 Parameter ENABLE_EXT, default 1: 1 decodes j/addi/ori; 0 treats them as illegal.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port op, input, 6: opcode field from the instruction register.
REQ-006 Port mem_ready, input, 1: memory handshake; tie high for single-cycle memory.
REQ-007 Ports regDst, aluSrcA, memToReg, regWrite, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, outputs, 1 each: datapath controls.
REQ-008 Ports aluSrcB and pcSource, outputs, 2 each: datapath mux selects.
REQ-009 Port alu_op, output, ALU_OP_W: 000 add, 001 sub, 010 funct-decode, 011 or; upper bits zero.
REQ-010 Port instr_done, output, 1: one-cycle pulse in the last state of each instruction.
REQ-011 Port illegal_op, output, 1: one-cycle pulse on an undecoded opcode.

Function
REQ-012 Outputs SHALL be Moore, decoded from state only; every output is 0 unless listed for the state.
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BEQ, JUMP, I_EXEC, I_WB, ILLEGAL.
REQ-014 IDLE: all outputs 0; next state FETCH.
REQ-015 FETCH: memRead=1, irWrite=1, aluSrcB=01, alu_op=000, pcWrite=1.
- Stays in FETCH while mem_ready=0; pcWrite and irWrite SHALL be 0 while waiting.
- Goes to DECODE when mem_ready=1.
REQ-016 DECODE: aluSrcB=11, alu_op=000. Next state by op:
- 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BEQ
- 000010 -> JUMP
- 001000 or 001101 -> I_EXEC
- any other opcode -> ILLEGAL
REQ-017 MEM_ADDR: aluSrcA=1, aluSrcB=10, alu_op=000; goes to MEM_RD for lw, MEM_WR for sw.
REQ-018 MEM_RD: memRead=1, iorD=1; waits on mem_ready=0, then goes to MEM_WB.
REQ-019 MEM_WB: regWrite=1, memToReg=1, regDst=0, instr_done=1; next state FETCH.
REQ-020 MEM_WR: memWrite=1, iorD=1; waits on mem_ready=0; instr_done=1 only in the cycle mem_ready=1, then goes to FETCH.
REQ-021 R_EXEC: aluSrcA=1, aluSrcB=00, alu_op=010; next state R_WB. R_WB: regDst=1, regWrite=1, instr_done=1; next state FETCH.
REQ-022 BEQ: aluSrcA=1, aluSrcB=00, alu_op=001, pcWriteCond=1, pcSource=01, instr_done=1; next state FETCH.
REQ-023 JUMP: pcWrite=1, pcSource=10, instr_done=1; next state FETCH.
REQ-024 I_EXEC: aluSrcA=1, aluSrcB=10, alu_op=000 for addi or 011 for ori; next state I_WB. I_WB: regWrite=1, regDst=0, memToReg=0, instr_done=1; next state FETCH.
REQ-025 ILLEGAL: illegal_op=1, instr_done=1; next state FETCH. PC has already advanced in FETCH, so the instruction is skipped.
REQ-026 The opcode SHALL be sampled from the IR (op) at DECODE and in the states that branch on it; op SHALL be stable from DECODE until instr_done.
REQ-027 Latency with mem_ready=1: lw 5 cycles; sw, R-type, addi, ori 4 cycles; beq, j, illegal 3 cycles.

Reset
REQ-028 rst_n=0 SHALL force state IDLE immediately, independent of clk, and all outputs SHALL be 0 while asserted.
REQ-029 Reset mid-instruction SHALL abandon the instruction with no further pcWrite, regWrite or memWrite.
REQ-030 The first FETCH SHALL occur on the second rising edge after rst_n deasserts.

Structure
REQ-031 Package mips_ctrl_pkg SHALL hold the opcode constants, state encodings, alu_op codes, and aluSrcB/pcSource codes.
REQ-032 Sub-module mc_ctrl_decode SHALL be the pure state-to-output decoder; the FSM register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-033 op=000000, mem_ready=1 -> FETCH, DECODE, R_EXEC (alu_op=010), R_WB (regDst=1, regWrite=1, instr_done=1) -> FETCH.
REQ-034 op=100011, mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with memRead=1, iorD=1; MEM_WB memToReg=1, regWrite=1; total 7 cycles.
REQ-035 op=101011 -> MEM_WR memWrite=1, regWrite=0 throughout; op=000100 -> BEQ alu_op=001, pcWriteCond=1, pcSource=01.
REQ-036 ENABLE_EXT=0 with op=001000 -> ILLEGAL, illegal_op pulses once, regWrite never 1; ENABLE_EXT=1 with op=001101 -> I_EXEC alu_op=011.
REQ-037 rst_n pulled low mid-MEM_WR -> memWrite drops to 0 at once with no clock edge; IDLE then FETCH after release.
REQ-038 op=111111 -> illegal_op=1 for exactly 1 cycle; next state FETCH with memRead=1.
